// File: rtl/shift_add_mult_seq.sv
// ---------------------------------------------------------------------------
// shift_add_mult_seq
//
// Sequential shift-add multiplier with its own control FSM and datapath.
// The operands are captured on an accepted start, magnitudes are multiplied
// by iterated add-and-shift, and the signed result is written once into a
// held product register together with the number of iterations used.
//
// Parameters
//   WIDTH        operand width in bits (>= 2); product is 2*WIDTH bits
//   SIGNED_MODE  0: unsigned operands, 1: two's-complement operands/product
//   EARLY_TERM   1: stop iterating once the remaining multiplier bits are 0
//                0: always WIDTH iterations
//
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    request, sampled only while IDLE
//   a        multiplicand, captured when start is accepted
//   b        multiplier, captured when start is accepted
//   product  registered result, held until the next completion
//   busy     high while in CALC and DONE
//   done     one-cycle pulse while in DONE
//   cycles   CALC iterations used by the last operation, held
// ---------------------------------------------------------------------------
module shift_add_mult_seq #(
  parameter int WIDTH       = 8,
  parameter bit SIGNED_MODE = 1'b0,
  parameter bit EARLY_TERM  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  output logic [2*WIDTH-1:0]           product,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   cycles
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   m_reg;   // shifted multiplicand magnitude
  logic [WIDTH-1:0]     q_reg;   // remaining multiplier magnitude bits
  logic [2*WIDTH-1:0]   acc;     // partial-product accumulator
  logic [CW-1:0]        count;   // iterations completed so far
  logic                 sign;    // result must be negated

  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   product_next;
  logic                 last_iter;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  // NOTE: every variable written here gets a value on every path (defaults
  // first), so no latch can be inferred.
  always_comb begin
    abs_a        = a;
    abs_b        = b;
    acc_next     = acc;
    product_next = '0;
    last_iter    = 1'b0;

    // Negating the most negative value wraps to 2^(WIDTH-1), which is the
    // correct magnitude when read as unsigned.
    if (SIGNED_MODE && a[WIDTH-1]) abs_a = -a;
    if (SIGNED_MODE && b[WIDTH-1]) abs_b = -b;

    if (q_reg[0]) acc_next = acc + m_reg;

    // Exit is decided on the current Q: when only bit 0 is left, this
    // cycle's add is the last useful one.
    last_iter = (count == CW'(WIDTH - 1)) ||
                (EARLY_TERM && (q_reg[WIDTH-1:1] == '0));

    product_next = sign ? -acc_next : acc_next;
  end

  // -------------------------------------------------------------------------
  // FSM and datapath
  // -------------------------------------------------------------------------
  // NOTE: all state and datapath registers are cleared by rst_n, so an
  // operation interrupted by reset leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      m_reg   <= '0;
      q_reg   <= '0;
      acc     <= '0;
      count   <= '0;
      sign    <= 1'b0;
      product <= '0;
      cycles  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // sees the pre-edge values of the others.
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= {{WIDTH{1'b0}}, abs_a};
            q_reg <= abs_b;
            acc   <= '0;
            count <= '0;
            sign  <= SIGNED_MODE ? (a[WIDTH-1] ^ b[WIDTH-1]) : 1'b0;
            state <= CALC;
          end
        end

        CALC: begin
          acc   <= acc_next;
          m_reg <= m_reg << 1;
          q_reg <= q_reg >> 1;
          count <= count + 1'b1;
          if (last_iter) begin
            product <= product_next;
            cycles  <= count + 1'b1;
            state   <= DONE;
          end
        end

        DONE: begin
          // start is not queued here; it must be presented again in IDLE.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status flags are a pure decode of the state register; the unused
  // encoding decodes as IDLE.
  assign busy = (state == CALC) || (state == DONE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_shift_add_mult_seq
//
// Bench for shift_add_mult_seq. Three 8-bit instances (unsigned/early-term,
// signed/early-term, unsigned/full-width) share a and b and have separate
// start lines; a 16-bit full-width instance has its own inputs. Expected
// results are pushed to a scoreboard when an operation is launched and
// popped by a monitor when the matching done pulse appears.
// ---------------------------------------------------------------------------
module tb_shift_add_mult_seq;

  logic clk;
  logic rst_n;

  // 8-bit instances
  logic [2:0]  start8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8 [3];
  logic [2:0]  busy8, done8;
  logic [3:0]  cyc8 [3];

  // 16-bit instance
  logic        start16;
  logic [15:0] a16, b16;
  logic [31:0] prod16;
  logic        busy16, done16;
  logic [4:0]  cyc16;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int          sel;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    logic [3:0]  cyc;
  } vec_t;

  typedef struct {
    int          sel;
    logic [15:0] prod;
    logic [3:0]  cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [2:0] done_prev;

  shift_add_mult_seq #(.WIDTH(8), .SIGNED_MODE(1'b0), .EARLY_TERM(1'b1)) u_uns (
    .clk(clk), .rst_n(rst_n), .start(start8[0]), .a(a8), .b(b8),
    .product(prod8[0]), .busy(busy8[0]), .done(done8[0]), .cycles(cyc8[0]));

  shift_add_mult_seq #(.WIDTH(8), .SIGNED_MODE(1'b1), .EARLY_TERM(1'b1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .start(start8[1]), .a(a8), .b(b8),
    .product(prod8[1]), .busy(busy8[1]), .done(done8[1]), .cycles(cyc8[1]));

  shift_add_mult_seq #(.WIDTH(8), .SIGNED_MODE(1'b0), .EARLY_TERM(1'b0)) u_full (
    .clk(clk), .rst_n(rst_n), .start(start8[2]), .a(a8), .b(b8),
    .product(prod8[2]), .busy(busy8[2]), .done(done8[2]), .cycles(cyc8[2]));

  shift_add_mult_seq #(.WIDTH(16), .SIGNED_MODE(1'b0), .EARLY_TERM(1'b0)) u_w16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
    .product(prod16), .busy(busy16), .done(done16), .cycles(cyc16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse, checks done width.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (done8[i]) begin
          check("done_one_cycle", 64'(done_prev[i]), 64'd0);
          if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_done: dut %0d pulsed done with empty scoreboard", i);
          end else begin
            mon_e = sb.pop_front();
            check("sb_dut", 64'(i), 64'(mon_e.sel));
            check("product", 64'(prod8[i]), 64'(mon_e.prod));
            check("cycles", 64'(cyc8[i]), 64'(mon_e.cyc));
          end
        end
        done_prev[i] = done8[i];
      end
    end else begin
      done_prev = '0;
    end
  end

  // Samples #1 after each rising edge until done is seen or budget expires.
  // n enters as the index of the last edge already passed.
  task automatic wait_done(input int sel, inout int n, input int budget);
    while (!done8[sel] && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done8[sel]) begin
      n_checks++;
      n_err++;
      $display("FAIL timeout: dut %0d no done within %0d edges", sel, budget);
    end
  endtask

  // One-cycle start pulse; checks busy, done latency and the return to IDLE.
  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] ep, input logic [3:0] ec);
    int n;
    exp_t e;
    @(negedge clk);
    a8 = a;
    b8 = b;
    start8[sel] = 1'b1;
    e.sel = sel; e.prod = ep; e.cyc = ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start8[sel] = 1'b0;
    check("busy_after_start", 64'(busy8[sel]), 64'd1);
    n = 0;
    wait_done(sel, n, 40);
    check("done_latency", 64'(n), 64'(ec));
    @(posedge clk);
    #1;
    check("idle_after_done", 64'(busy8[sel]), 64'd0);
  endtask

  vec_t vecs[13];
  int   n;

  initial begin
    rst_n = 1'b0;
    start8 = '0;
    a8 = '0;
    b8 = '0;
    start16 = 1'b0;
    a16 = '0;
    b16 = '0;

    vecs[0]  = '{0, 8'd13,  8'd11,  16'h008F, 4'd4};
    vecs[1]  = '{0, 8'd255, 8'd255, 16'hFE01, 4'd8};
    vecs[2]  = '{0, 8'd200, 8'd0,   16'h0000, 4'd1};
    vecs[3]  = '{0, 8'd1,   8'd128, 16'h0080, 4'd8};
    vecs[4]  = '{0, 8'd128, 8'd1,   16'h0080, 4'd1};
    vecs[5]  = '{1, 8'h80,  8'h80,  16'h4000, 4'd8};
    vecs[6]  = '{1, 8'hFD,  8'd5,   16'hFFF1, 4'd3};
    vecs[7]  = '{1, 8'h7F,  8'h81,  16'hC0FF, 4'd7};
    vecs[8]  = '{1, 8'h80,  8'h01,  16'hFF80, 4'd1};
    vecs[9]  = '{1, 8'hFB,  8'h00,  16'h0000, 4'd1};
    vecs[10] = '{2, 8'd9,   8'd1,   16'h0009, 4'd8};
    vecs[11] = '{2, 8'd255, 8'd255, 16'hFE01, 4'd8};
    vecs[12] = '{2, 8'd0,   8'd0,   16'h0000, 4'd8};

    // Reset state
    #3;
    check("rst_product", 64'(prod8[0]), 64'd0);
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_cycles", 64'(cyc8[0]), 64'd0);
    check("rst_product16", 64'(prod16), 64'd0);
    #14;
    rst_n = 1'b1;

    // Table-driven operations
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].cyc);
    end

    // start held high, operands changed during CALC: 13*11 then 255*255,
    // separated by one DONE cycle and one IDLE cycle.
    @(negedge clk);
    a8 = 8'd13;
    b8 = 8'd11;
    start8[0] = 1'b1;
    sb.push_back('{0, 16'h008F, 4'd4});
    sb.push_back('{0, 16'hFE01, 4'd8});
    @(posedge clk);
    #1;
    n = 0;
    @(posedge clk);
    #1;
    n++;
    a8 = 8'd255;
    b8 = 8'd255;
    wait_done(0, n, 40);
    check("held_first_latency", 64'(n), 64'd4);
    @(posedge clk);
    #1;
    n++;
    check("held_gap_busy", 64'(busy8[0]), 64'd0);
    @(posedge clk);
    #1;
    n++;
    check("held_reaccept_busy", 64'(busy8[0]), 64'd1);
    wait_done(0, n, 60);
    check("held_second_done_edge", 64'(n), 64'd14);
    start8[0] = 1'b0;
    @(posedge clk);
    #1;
    check("held_release_idle", 64'(busy8[0]), 64'd0);
    @(posedge clk);
    #1;
    check("held_no_restart", 64'(busy8[0]), 64'd0);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    a8 = 8'd255;
    b8 = 8'd255;
    start8[0] = 1'b1;
    @(posedge clk);
    #1;
    start8[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_product", 64'(prod8[0]), 64'd0);
    check("async_rst_busy", 64'(busy8[0]), 64'd0);
    check("async_rst_done", 64'(done8[0]), 64'd0);
    check("async_rst_cycles", 64'(cyc8[0]), 64'd0);
    sb.delete();
    #2;
    rst_n = 1'b1;
    run_op(0, 8'd6, 8'd7, 16'd42, 4'd3);

    // 16-bit full-width instance
    @(negedge clk);
    a16 = 16'hFFFF;
    b16 = 16'hFFFF;
    start16 = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    n = 0;
    while (!done16 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("w16_latency", 64'(n), 64'd16);
    check("w16_product", 64'(prod16), 64'hFFFE0001);
    check("w16_cycles", 64'(cyc16), 64'd16);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
